pe_feeder: RTL

- Transmit-side companion to the pe convolution element: it sources the pe_in/pe_filter operand pairs that the PE multiplies and accumulates over 3x3 windows.
- Holds a 9-tap filter register file, accepts a pixel stream over a valid/ready handshake, and emits one registered operand pair per accepted pixel.
- Emits tap-position flags, counts completed windows, and signals completion of a programmed run.

---
 rtl/pe_feeder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pe_feeder.sv
// -----------------------------------------------------------------------------
// pe_feeder
// Feeds operand pairs to the pe convolution element. A 9-tap weight register
// file is loaded while idle. A run is then started, and the feeder accepts one
// pixel per handshake. For each accepted pixel it emits a registered
// (pixel, weight[tap]) pair one cycle later, together with tap-0 and tap-last
// flags. It counts completed windows and pulses done when the run ends.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   w_wr       in   weight write strobe (honoured only while idle)
//   w_addr     in   weight tap index; indices >= TAPS are ignored
//   w_data     in   weight value
//   start      in   one-cycle run start pulse
//   win_count  in   windows in the run, sampled with start
//   in_valid   in   pixel valid
//   in_ready   out  feeder accepts a pixel this cycle
//   in_data    in   pixel value
//   pe_in      out  pixel operand to the PE
//   pe_filter  out  weight operand to the PE
//   pe_valid   out  operand pair valid
//   pe_first   out  pair is tap 0 of a window
//   pe_last    out  pair is tap TAPS-1 of a window
//   busy       out  run in progress
//   done       out  one-cycle pulse at the end of a run
// -----------------------------------------------------------------------------
module pe_feeder #(
  parameter int DW    = 8,
  parameter int TAPS  = 9,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_wr,
  input  logic [3:0]       w_addr,
  input  logic [DW-1:0]    w_data,
  input  logic             start,
  input  logic [WIN_W-1:0] win_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic [DW-1:0]    pe_in,
  output logic [DW-1:0]    pe_filter,
  output logic             pe_valid,
  output logic             pe_first,
  output logic             pe_last,
  output logic             busy,
  output logic             done
);

  localparam int TW = $clog2(TAPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state_r;
  logic [TW-1:0]     tap_r;
  logic [WIN_W-1:0]  win_r;
  logic [DW-1:0]     weight_r [TAPS];

  logic              last_tap_s;
  logic              w_en_s;

  // The feeder is ready for exactly the cycles it spends in STREAM.
  assign in_ready   = (state_r == STREAM);
  assign last_tap_s = (tap_r == TW'(TAPS - 1));
  // Weights are frozen outside IDLE so a run always sees a consistent kernel.
  assign w_en_s     = (state_r == IDLE) && w_wr && (w_addr < 4'(TAPS));

  // Weight register file: written only while idle, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        weight_r[i] <= '0;
      end
    end else if (w_en_s) begin
      weight_r[w_addr] <= w_data;
    end
  end

  // Run control FSM with registered operand, flag and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      tap_r     <= '0;
      win_r     <= '0;
      pe_in     <= '0;
      pe_filter <= '0;
      pe_valid  <= 1'b0;
      pe_first  <= 1'b0;
      pe_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Per-cycle pulses default low; pe_in/pe_filter hold across bubbles.
      pe_valid <= 1'b0;
      pe_first <= 1'b0;
      pe_last  <= 1'b0;
      done     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            tap_r <= '0;
            if (win_count != '0) begin
              win_r   <= win_count;
              state_r <= STREAM;
            end else begin
              // Empty run: skip streaming and still report completion.
              state_r <= FINISH;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        STREAM: begin
          busy <= 1'b1;
          if (in_valid) begin
            pe_in     <= in_data;
            pe_filter <= weight_r[tap_r];
            pe_valid  <= 1'b1;
            pe_first  <= (tap_r == '0);
            pe_last   <= last_tap_s;
            if (last_tap_s) begin
              tap_r <= '0;
              win_r <= win_r - WIN_W'(1);
              // Last tap of the last window ends the stream.
              if (win_r == WIN_W'(1)) begin
                state_r <= FINISH;
              end else begin
                state_r <= STREAM;
              end
            end else begin
              tap_r <= tap_r + TW'(1);
            end
          end else begin
            tap_r <= tap_r;
          end
        end
        FINISH: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
